player_move_ctrl: RTL and testbench
===================================

# player_move_ctrl

Player movement controller that sits directly upstream of the sprite renderer and VGA compositor. It turns debounced direction-button levels into a smooth one-tile walk of the player sprite. It drives the sprite's top-left screen position, facing direction and walk-animation frame, which the renderer uses to select the sprite ROM and compute pixel addresses. One move command advances the sprite exactly one tile (`STEP_LEN` pixels), one pixel every `STEP_DELAY` clocks.

## Interface
Parameters:
- `START_R`, default 300: row of the sprite after reset.
- `START_C`, default 300: column of the sprite after reset.
- `STEP_LEN`, default 32: pixels per move; must be even.
- `STEP_DELAY`, default 32: clocks per 1-pixel advance; must be ≥1.
- `MIN_R`, default 0: minimum legal row.
- `MAX_R`, default 448: maximum legal row.
- `MIN_C`, default 0: minimum legal column.
- `MAX_C`, default 608: maximum legal column.

Ports:
- `clk`, in, 1: the single clock; all logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, in, 1 each: debounced button levels, already synchronous to `clk`.
- `pos_r`, out, 10: sprite top row.
- `pos_c`, out, 10: sprite left column.
- `facing`, out, 2: facing direction; 0 = down, 1 = up, 2 = left, 3 = right.
- `frame`, out, 1: walk-animation frame select.
- `moving`, out, 1: high while in the MOVE state.
- `step_done`, out, 1: one-cycle pulse when a move completes.

## Operation
- **States.** Two states, IDLE and MOVE. Internal counters:
  - `pix_cnt`: pixels left in the current move, width clog2(`STEP_LEN`)+1.
  - `dly_cnt`: clocks left before the next pixel advance, width clog2(`STEP_DELAY`)+1.
- **Reset values.** `pos_r`=`START_R`, `pos_c`=`START_C`, `facing`=0, `frame`=0, `moving`=0, `step_done`=0, state IDLE, both counters 0.
- **IDLE, command selection.**
  - Fixed priority when several buttons are high: up > down > left > right.
  - Selecting a button sets `facing` to that direction at the next edge.
- **IDLE, bounds check.** Evaluated with 11-bit arithmetic so there is no wrap:
  - up is legal if `pos_r` ≥ `MIN_R`+`STEP_LEN`;
  - down is legal if `pos_r`+`STEP_LEN` ≤ `MAX_R`;
  - left is legal if `pos_c` ≥ `MIN_C`+`STEP_LEN`;
  - right is legal if `pos_c`+`STEP_LEN` ≤ `MAX_C`.
- **IDLE, outcome.**
  - Legal move: go to MOVE, load `pix_cnt`=`STEP_LEN` and `dly_cnt`=`STEP_DELAY`-1.
  - Illegal move: turn in place only. `facing` updates, the state stays IDLE, and `step_done` is not asserted.
- **MOVE.**
  - All buttons are ignored.
  - If `dly_cnt`≠0, decrement it.
  - If `dly_cnt`==0:
    - move the position 1 pixel in the `facing` direction;
    - decrement `pix_cnt` and reload `dly_cnt`=`STEP_DELAY`-1;
    - if `pix_cnt` was 1, go to IDLE and pulse `step_done` at the same edge.
- **Frame select.**
  - `frame` = 0 in IDLE.
  - In MOVE: `frame` = 0 while `pix_cnt` > `STEP_LEN`/2, and 1 otherwise.
  - `frame` is registered and updates on the same edge as `pix_cnt`.
- **Direction hold.** `facing` never changes during MOVE.
- **Mid-operation reset.** Reset during MOVE returns immediately to reset values. The position snaps to `START_R`/`START_C`, even when that is off the tile grid.

## Timing
- **Start.** A button sampled high in IDLE at edge N gives `moving`=1 and the new `facing` after edge N.
- **Pixel advances.** The first advance is visible after edge N+`STEP_DELAY`. Advance k is visible after edge N+k·`STEP_DELAY`.
- **Completion.**
  - The final advance and the return to IDLE both happen at edge N+`STEP_LEN`·`STEP_DELAY`.
  - `moving` is high for exactly `STEP_LEN`·`STEP_DELAY` cycles.
  - `step_done` is high for exactly one cycle, the first IDLE cycle.
- **Held button.** A button held through completion is accepted in that first IDLE cycle. The next MOVE begins one cycle later, so continuous walking has exactly a one-cycle gap between moves.
- **Press during MOVE.** A press that starts and ends inside MOVE has no effect; there is no command queue.
- **Output glitches.** All outputs are registered, with no combinational path from any button to any output.

## Test plan
Simulation parameters for all scenarios: `STEP_LEN`=32, `STEP_DELAY`=4, default bounds.
- **Reset.**
  - Stimulus: assert `rst` for 2 cycles with all buttons low.
  - Required: `pos`=(300,300), `facing`=0, `frame`=0, `moving`=0, `step_done`=0.
- **Single move down.**
  - Stimulus: from reset, pulse `btn_down` for 1 cycle.
  - Required: `moving` high for 128 cycles.
  - Required: `pos_r` steps 301, 302, … 332, one step every 4 cycles.
  - Required: `frame` is 0 through `pos_r`=316 and 1 from 317 on.
  - Required: `step_done` pulses once, in the cycle where `pos_r`=332.
- **Priority.**
  - Stimulus: `btn_up` and `btn_right` high together.
  - Required: `facing`=1 and `pos_r` ends at 268; `pos_c` unchanged.
- **Boundary / turn in place.**
  - Stimulus: reset with `START_R`=10, then press up.
  - Required: `facing`=1, `moving` stays 0, `pos_r`=10 unchanged, no `step_done` pulse.
- **Held button.**
  - Stimulus: hold `btn_left` for 300 cycles.
  - Required: two full moves, `pos_c` 300 → 268 → 236.
  - Required: exactly 1 cycle of `moving`=0 between the two moves.
- **Reset mid-move and ignored input.**
  - Stimulus: press right, then press up 20 cycles into the move.
  - Required: the up press is ignored; `facing` stays 3.
  - Stimulus: assert `rst` 60 cycles into the move.
  - Required: next cycle shows `pos`=(300,300), `moving`=0, `frame`=0.

Source files
------------

// File: rtl/player_move_ctrl.sv
// Purpose: turns debounced direction buttons into a one-tile sprite walk (position, facing, walk frame).
// Latency: button sampled in IDLE -> moving/facing next cycle; first pixel after STEP_DELAY clocks; move lasts STEP_LEN*STEP_DELAY.
// Backpressure: none; buttons are ignored while a move is in progress (no command queue).
module player_move_ctrl #(
  parameter int START_R    = 300,
  parameter int START_C    = 300,
  parameter int STEP_LEN   = 32,
  parameter int STEP_DELAY = 32,
  parameter int MIN_R      = 0,
  parameter int MAX_R      = 448,
  parameter int MIN_C      = 0,
  parameter int MAX_C      = 608
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [9:0] pos_r,
  output logic [9:0] pos_c,
  output logic [1:0] facing,
  output logic       frame,
  output logic       moving,
  output logic       step_done
);

  localparam int PW = $clog2(STEP_LEN) + 1;
  localparam int DW = $clog2(STEP_DELAY) + 1;

  localparam logic [1:0] DIR_DOWN  = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic {S_IDLE, S_MOVE} state_t;

  state_t        state;
  logic [PW-1:0] pix_cnt;
  logic [DW-1:0] dly_cnt;

  logic          any_btn;
  logic [1:0]    sel_dir;
  logic          sel_ok;
  logic [10:0]   r11;
  logic [10:0]   c11;

  assign any_btn = btn_up | btn_down | btn_left | btn_right;
  assign r11     = {1'b0, pos_r};
  assign c11     = {1'b0, pos_c};

  // Pick the highest-priority button and check that a full tile fits inside the bounds (11-bit, no wrap).
  always_comb begin
    sel_dir = DIR_RIGHT;
    sel_ok  = 1'b0;
    if (btn_up) begin
      sel_dir = DIR_UP;
      sel_ok  = r11 >= 11'(MIN_R + STEP_LEN);
    end else if (btn_down) begin
      sel_dir = DIR_DOWN;
      sel_ok  = (r11 + 11'(STEP_LEN)) <= 11'(MAX_R);
    end else if (btn_left) begin
      sel_dir = DIR_LEFT;
      sel_ok  = c11 >= 11'(MIN_C + STEP_LEN);
    end else if (btn_right) begin
      sel_dir = DIR_RIGHT;
      sel_ok  = (c11 + 11'(STEP_LEN)) <= 11'(MAX_C);
    end
  end

  // IDLE/MOVE state machine with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pos_r     <= 10'(START_R);
      pos_c     <= 10'(START_C);
      facing    <= DIR_DOWN;
      frame     <= 1'b0;
      moving    <= 1'b0;
      step_done <= 1'b0;
      pix_cnt   <= '0;
      dly_cnt   <= '0;
    end else begin
      step_done <= 1'b0;
      case (state)
        S_IDLE: begin
          frame <= 1'b0;
          if (any_btn) begin
            // An illegal move still turns the sprite in place.
            facing <= sel_dir;
            if (sel_ok) begin
              state   <= S_MOVE;
              moving  <= 1'b1;
              pix_cnt <= PW'(STEP_LEN);
              dly_cnt <= DW'(STEP_DELAY - 1);
            end
          end
        end
        S_MOVE: begin
          if (dly_cnt != '0) begin
            dly_cnt <= dly_cnt - DW'(1);
          end else begin
            case (facing)
              DIR_DOWN: pos_r <= pos_r + 10'd1;
              DIR_UP:   pos_r <= pos_r - 10'd1;
              DIR_LEFT: pos_c <= pos_c - 10'd1;
              default:  pos_c <= pos_c + 10'd1;
            endcase
            pix_cnt <= pix_cnt - PW'(1);
            dly_cnt <= DW'(STEP_DELAY - 1);
            if (pix_cnt == PW'(1)) begin
              state     <= S_IDLE;
              moving    <= 1'b0;
              step_done <= 1'b1;
              frame     <= 1'b0;
            end else begin
              // Frame is judged on the pixel count before this advance.
              frame <= (pix_cnt <= PW'(STEP_LEN / 2));
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_player_move_ctrl.sv
module tb_player_move_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [9:0] pos_r, pos_c;
  logic [1:0] facing;
  logic       frame, moving, step_done;

  logic       b10_up = 1'b0;
  logic [9:0] pos_r10, pos_c10;
  logic [1:0] facing10;
  logic       frame10, moving10, step_done10;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  player_move_ctrl #(.STEP_LEN(32), .STEP_DELAY(4)) u_dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .pos_r(pos_r), .pos_c(pos_c), .facing(facing), .frame(frame),
    .moving(moving), .step_done(step_done)
  );

  player_move_ctrl #(.START_R(10), .STEP_LEN(32), .STEP_DELAY(4)) u_dut10 (
    .clk(clk), .rst(rst),
    .btn_up(b10_up), .btn_down(1'b0), .btn_left(1'b0), .btn_right(1'b0),
    .pos_r(pos_r10), .pos_c(pos_c10), .facing(facing10), .frame(frame10),
    .moving(moving10), .step_done(step_done10)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int gaps;
    int pulses;
    int adv;

    // Reset for two cycles, all buttons low.
    tick();
    tick();
    chk("rst_pos_r", 32'(pos_r), 300);
    chk("rst_pos_c", 32'(pos_c), 300);
    chk("rst_facing", 32'(facing), 0);
    chk("rst_frame", 32'(frame), 0);
    chk("rst_moving", 32'(moving), 0);
    chk("rst_step_done", 32'(step_done), 0);
    chk("rst10_pos_r", 32'(pos_r10), 10);
    rst = 1'b0;

    // Boundary: row 10 cannot move up, only turns.
    b10_up = 1'b1;
    tick();
    b10_up = 1'b0;
    chk("bnd_facing", 32'(facing10), 1);
    chk("bnd_moving", 32'(moving10), 0);
    chk("bnd_pos_r", 32'(pos_r10), 10);
    pulses = 32'(step_done10);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (moving10) pulses++;
      if (step_done10) pulses++;
    end
    chk("bnd_no_move_no_done", 32'(pulses), 0);
    chk("bnd_pos_r_after", 32'(pos_r10), 10);

    // Single move down, 1-cycle pulse.
    btn_down = 1'b1;
    tick();
    btn_down = 1'b0;
    chk("down_start_moving", 32'(moving), 1);
    chk("down_start_facing", 32'(facing), 0);
    chk("down_start_pos_r", 32'(pos_r), 300);
    pulses = 0;
    for (int k = 1; k <= 128; k++) begin
      tick();
      adv = k / 4;
      chk("down_pos_r", 32'(pos_r), 32'(300 + adv));
      chk("down_frame", 32'(frame), (adv >= 17 && adv <= 31) ? 32'd1 : 32'd0);
      chk("down_moving", 32'(moving), (k < 128) ? 32'd1 : 32'd0);
      if (step_done) pulses++;
    end
    chk("down_done_at_332", 32'(step_done), 1);
    tick();
    if (step_done) pulses++;
    chk("down_done_pulses", 32'(pulses), 1);
    chk("down_pos_c", 32'(pos_c), 300);

    // Priority: up beats right.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    btn_up = 1'b1;
    btn_right = 1'b1;
    tick();
    btn_up = 1'b0;
    btn_right = 1'b0;
    chk("prio_facing", 32'(facing), 1);
    for (int k = 1; k <= 128; k++) tick();
    chk("prio_pos_r", 32'(pos_r), 268);
    chk("prio_pos_c", 32'(pos_c), 300);
    chk("prio_done", 32'(step_done), 1);

    // Held left for 300 cycles: two full moves with one idle cycle between.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    btn_left = 1'b1;
    gaps = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (k >= 1 && k <= 256 && !moving) gaps++;
      if (k == 127) chk("held_moving_127", 32'(moving), 1);
      if (k == 128) begin
        chk("held_pos_c_1", 32'(pos_c), 268);
        chk("held_moving_128", 32'(moving), 0);
      end
      if (k == 129) chk("held_moving_129", 32'(moving), 1);
      if (k == 257) begin
        chk("held_pos_c_2", 32'(pos_c), 236);
        chk("held_done_2", 32'(step_done), 1);
      end
    end
    btn_left = 1'b0;
    chk("held_gap_cycles", 32'(gaps), 1);
    chk("held_facing", 32'(facing), 2);

    // Press right, ignore a mid-move up press, then reset mid-move.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    btn_right = 1'b1;
    tick();
    btn_right = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 20) btn_up = 1'b1;
      if (k == 24) btn_up = 1'b0;
      if (k == 25) begin
        chk("mid_facing", 32'(facing), 3);
        chk("mid_moving", 32'(moving), 1);
        chk("mid_pos_r", 32'(pos_r), 300);
      end
    end
    chk("mid_pos_c_60", 32'(pos_c), 315);
    chk("mid_facing_60", 32'(facing), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_pos_r", 32'(pos_r), 300);
    chk("mrst_pos_c", 32'(pos_c), 300);
    chk("mrst_moving", 32'(moving), 0);
    chk("mrst_frame", 32'(frame), 0);
    chk("mrst_facing", 32'(facing), 0);
    tick();
    chk("mrst_stays_idle", 32'(moving), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
